// File: rtl/lrsc_pkg.sv
// Shared types and constants for the LR/SC reservation unit.
// The entry fields are sized for the widest configuration the unit supports:
// 64-bit byte addresses and a 32-bit age. Narrower instances zero-extend
// into these fields, and the constant upper bits fold away in synthesis.
package lrsc_pkg;

    localparam int RES_WORD_W = 62;
    localparam int RES_AGE_W  = 32;

    localparam logic [31:0] SC_PASS_VAL = 32'd0;
    localparam logic [31:0] SC_FAIL_VAL = 32'd1;

    typedef enum logic [1:0] {
        OP_NONE = 2'd0,
        OP_LR   = 2'd1,
        OP_SC   = 2'd2,
        OP_ST   = 2'd3
    } op_kind_e;

    typedef struct packed {
        logic                  valid;
        logic [RES_WORD_W-1:0] addr;
        logic [RES_AGE_W-1:0]  age;
    } res_entry_t;

    // The decoder should raise only one strobe per cycle. If it raises
    // several, SC wins over LR, and LR wins over a plain store.
    function automatic op_kind_e decode_op(input logic lr_valid,
                                           input logic sc_valid,
                                           input logic st_valid);
        op_kind_e kind;
        kind = OP_NONE;
        if (sc_valid) begin
            kind = OP_SC;
        end else if (lr_valid) begin
            kind = OP_LR;
        end else if (st_valid) begin
            kind = OP_ST;
        end
        return kind;
    endfunction

endpackage

// File: rtl/lrsc_res_entry.sv
// A reservation entry for one hart. It holds a valid bit, the reserved word
// address and an age counter. A set (LR) takes priority over everything
// else, so an LR issued on the cycle the entry expires keeps it alive.
// Age is only tracked while the entry is valid. The entry expires on the
// edge at which the age counter reaches TIMEOUT, which gives exactly
// TIMEOUT usable cycles after the LR.
module lrsc_res_entry import lrsc_pkg::*; #(
    parameter int WORD_W  = 30,
    parameter int TIMEOUT = 255,
    parameter int CNT_W   = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              set,
    input  logic              clear,
    input  logic              age_en,
    input  logic [WORD_W-1:0] word,
    output logic              valid,
    output logic [WORD_W-1:0] addr,
    output logic              match
);

    // Last age value at which the entry is still usable. One more cycle of
    // ageing takes the counter to TIMEOUT, and the entry drops at that point.
    localparam logic [CNT_W-1:0] AGE_LAST = CNT_W'(TIMEOUT - 1);

    res_entry_t entry_q;
    res_entry_t entry_d;

    // Next-state logic for the entry: set, then clear, then ageing/expiry.
    always_comb begin
        entry_d = entry_q;
        if (set) begin
            entry_d.valid = 1'b1;
            entry_d.addr  = RES_WORD_W'(word);
            entry_d.age   = '0;
        end else if (clear) begin
            entry_d.valid = 1'b0;
        end else if (age_en && entry_q.valid) begin
            entry_d.age = entry_q.age + RES_AGE_W'(1);
            if (entry_q.age == RES_AGE_W'(AGE_LAST)) begin
                entry_d.valid = 1'b0;
            end
        end
    end

    // Entry state register. Reset drops the reservation and zeroes the fields.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            entry_q <= '0;
        end else begin
            entry_q <= entry_d;
        end
    end

    assign valid = entry_q.valid;
    assign addr  = entry_q.addr[WORD_W-1:0];
    assign match = entry_q.valid && (entry_q.addr == RES_WORD_W'(word));

endmodule

// File: rtl/lrsc_reservation_unit.sv
// LR/SC reservation unit for the barrel core. It keeps one reservation per
// hart, resolves store-conditionals in the same cycle they execute, and
// invalidates reservations on conflicting stores, on a passing SC to the
// same word, and on timeout. Reservations use 32-bit word granularity.
module lrsc_reservation_unit import lrsc_pkg::*; #(
    parameter int NUM_HARTS = 16,
    parameter int ADDR_W    = 32,
    parameter int TIMEOUT   = 255,
    parameter int CNT_W     = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1,
    localparam int HART_W   = (NUM_HARTS > 1) ? $clog2(NUM_HARTS) : 1
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic [HART_W-1:0]    i_hart_id,
    input  logic                 i_lr_valid,
    input  logic                 i_sc_valid,
    input  logic                 i_st_valid,
    input  logic [ADDR_W-1:0]    i_addr,
    output logic                 o_sc_pass,
    output logic [31:0]          o_sc_rd,
    output logic [NUM_HARTS-1:0] o_res_valid
);

    localparam int   WORD_W = ADDR_W - 2;
    localparam logic AGE_ON = (TIMEOUT > 0);

    op_kind_e              op_kind;
    logic [WORD_W-1:0]     op_word;
    logic                  unused_byte_offset;
    logic                  age_en;

    logic [NUM_HARTS-1:0]  entry_set;
    logic [NUM_HARTS-1:0]  entry_clear;
    logic [NUM_HARTS-1:0]  entry_valid;
    logic [NUM_HARTS-1:0]  entry_match;
    logic [WORD_W-1:0]     entry_addr [NUM_HARTS];

    logic                  sel_valid;
    logic [WORD_W-1:0]     sel_addr;
    logic                  sc_pass;

    // The low two address bits pick a byte within the reserved word and
    // play no part in matching.
    assign op_word            = i_addr[ADDR_W-1:2];
    assign unused_byte_offset = ^i_addr[1:0];

    // With TIMEOUT of zero the age enable is tied low, so the counters
    // never advance and reservations persist until explicitly cleared.
    assign age_en = AGE_ON;

    // Collapse the decoder strobes into a single operation kind.
    always_comb begin
        op_kind = decode_op(i_lr_valid, i_sc_valid, i_st_valid);
    end

    // Evaluate the SC against the issuing hart's reservation as it stands
    // before the edge. An entry that expires on this edge still passes.
    always_comb begin
        sel_valid = entry_valid[i_hart_id];
        sel_addr  = entry_addr[i_hart_id];
        sc_pass   = (op_kind == OP_SC) && sel_valid && (sel_addr == op_word);
    end

    // Per-hart set/clear strobes: an LR sets the issuer's entry, and an SC
    // always clears the issuer's entry. A passing SC or any store also
    // clears every reservation that holds the same word.
    always_comb begin
        entry_set   = '0;
        entry_clear = '0;
        for (int h = 0; h < NUM_HARTS; h++) begin
            entry_set[h]   = (op_kind == OP_LR) && (i_hart_id == HART_W'(h));
            entry_clear[h] = ((op_kind == OP_SC) && (i_hart_id == HART_W'(h)))
                          || (sc_pass && entry_match[h])
                          || ((op_kind == OP_ST) && entry_match[h]);
        end
    end

    for (genvar h = 0; h < NUM_HARTS; h++) begin : g_entry
        lrsc_res_entry #(
            .WORD_W  (WORD_W),
            .TIMEOUT (TIMEOUT),
            .CNT_W   (CNT_W)
        ) u_entry (
            .clk    (i_clk),
            .rst_n  (i_rst_n),
            .set    (entry_set[h]),
            .clear  (entry_clear[h]),
            .age_en (age_en),
            .word   (op_word),
            .valid  (entry_valid[h]),
            .addr   (entry_addr[h]),
            .match  (entry_match[h])
        );
    end

    assign o_sc_pass   = sc_pass;
    assign o_sc_rd     = sc_pass ? SC_PASS_VAL : SC_FAIL_VAL;
    assign o_res_valid = entry_valid;

endmodule

// File: doc/lrsc_reservation_unit.md
# lrsc_reservation_unit

- Holds one load-reserved reservation per hardware thread (hart) of the barrel core.
- Decides pass/fail for every store-conditional.
- Invalidates reservations on conflicting stores and on timeout.
- Sits beside the data-memory port in the execute/memory stage. It is driven by the decoder's reservation-valid, store-conditional and memory-write strobes, and gates the SC write enable.

## Interface

Parameters:
- NUM_HARTS, 16: number of harts and reservation entries.
- ADDR_W, 32: byte address width.
- TIMEOUT, 255: cycles a reservation survives without a matching SC; 0 disables expiry.
- CNT_W, $clog2(TIMEOUT+1): age counter width (derived).

Ports:
- Clock and reset: one clock; reset is asynchronous and active-low (i_clk, i_rst_n).
- i_clk  in  1  clock.
- i_rst_n  in  1  asynchronous active-low reset.
- i_hart_id  in  $clog2(NUM_HARTS)  hart issuing this cycle's memory op.
- i_lr_valid  in  1  LR executing (decoder reservation-valid).
- i_sc_valid  in  1  SC executing (decoder store-cond).
- i_st_valid  in  1  ordinary store executing (decoder MemWr).
- i_addr  in  ADDR_W  effective address of the op.
- o_sc_pass  out  1  SC succeeds; gates the memory write this cycle.
- o_sc_rd  out  32  SC writeback value: 0 on pass, 1 on fail.
- o_res_valid  out  NUM_HARTS  per-hart reservation valid (debug/verification).

## Operation

- **Granule:** one 32-bit word. Matching compares i_addr[ADDR_W-1:2] only.
- **Op rules:**
  - At most one of i_lr_valid/i_sc_valid/i_st_valid is high per cycle.
  - If several are high, priority is SC > LR > store. The bench flags this as a protocol error.
- **Entry per hart:** valid, word address, age counter.
- **LR (hart h):**
  - Sets valid[h] and loads addr[h].
  - Clears age[h].
  - Overwrites any older reservation of h.
- **SC (hart h):**
  - o_sc_pass = valid[h] && addr[h]==i_addr word.
  - valid[h] clears regardless of outcome.
  - On pass, every other hart whose valid reservation matches the word is also cleared.
- **Store (any hart):** clears every hart's reservation, including the issuer's, whose addr matches the word.
- **Aging:**
  - Each valid entry increments age every cycle.
  - When age==TIMEOUT, valid clears on that edge.
  - Counter saturates and is not used while invalid.
- **Simultaneous events:**
  - LR to hart h in the same cycle h expires: the LR wins (valid=1, age=0).
  - Store or SC-pass invalidation coinciding with expiry: entry clears.
  - An SC evaluates against the pre-edge state, so an entry expiring on that same edge still passes.
- **o_sc_rd:** 32'd0 when o_sc_pass, else 32'd1. Meaningful only while i_sc_valid; otherwise it equals 32'd1.

## Timing

- o_sc_pass/o_sc_rd are combinational from i_sc_valid, i_hart_id, i_addr and registered entry state: zero latency, same cycle as the SC.
- All entry updates take effect on the rising i_clk edge following the op. An LR at cycle n is visible to an SC at cycle n+1.
- Reset (async assert, sync deassert handled upstream):
  - all valid=0, addr=0, age=0.
  - o_res_valid=0, o_sc_pass=0, o_sc_rd=32'd1.
- Reset mid-operation drops all reservations. The first SC after reset fails.
- TIMEOUT=0: age logic is removed and reservations persist until cleared by LR, SC or store.

## Structure

- **Shared package lrsc_pkg:**
  - res_entry_t struct (valid, word addr, age).
  - Op-kind enum (OP_NONE, OP_LR, OP_SC, OP_ST).
  - SC_PASS_VAL=0 and SC_FAIL_VAL=1.
- **Sub-module lrsc_res_entry:**
  - One per hart via generate.
  - Inputs: set, clear, age enable.
  - Outputs: valid, addr, match(word).
  - Top level does hart-id decode, match OR-ing and the SC mux.

## Test plan

- **Reset:** hold i_rst_n=0, then release; SC from hart 3 at 0x100 -> o_sc_pass=0, o_sc_rd=1, o_res_valid=0.
- **Basic pair:** LR hart 2 at 0x1000, next cycle SC hart 2 at 0x1000 -> o_sc_pass=1, o_sc_rd=0; repeat SC -> fail.
- **Cross-hart store kill:** LR hart 0 @0x2004 and LR hart 5 @0x2004; store hart 7 @0x2006 (same word) -> o_res_valid[0] and [5] clear; SC hart 0 fails.
- **Non-matching store:** LR hart 1 @0x3000; store hart 4 @0x3004 -> reservation kept; SC hart 1 @0x3000 passes.
- **Timeout, TIMEOUT=4:**
  - LR hart 6, SC 4 cycles later -> pass.
  - LR hart 6, SC 5 cycles later -> fail.
  - LR re-issued on the expiry cycle keeps valid=1.
- **SC-pass invalidation and address mismatch:**
  - Harts 1 and 2 LR @0x40; hart 1 SC passes -> o_res_valid[2]=0 next cycle, hart 2 SC fails.
  - SC to a different word fails and clears the issuer's reservation.
